mesh_task_scheduler: RTL and testbench
======================================

// Module: mesh_task_scheduler
// PURPOSE
// Shares the 3x3 mesh cores between a stream of task requests. Queues incoming tasks,
// tracks which cores are busy, picks a free, available core round-robin and hands
// (node, task) to the start-injection logic with a valid/ready handshake. Sits beside
// the NoC toplevel and consumes its per-node availability vector.
// PARAMETERS
// NODES       9  number of mesh nodes; node id = row*3 + col
// TASK_W      8  task identifier width
// FIFO_DEPTH  4  pending-task queue depth, power of 2, >=2
// PORTS
// clk             in   1                      system clock
// rst_n           in   1                      async active-low reset
// task_valid      in   1                      task request present
// task_id         in   TASK_W                 task identifier
// task_ready      out  1                      queue can accept (count < FIFO_DEPTH)
// core_avail      in   NODES                  1 = node populated/enabled, bit n = node n
// core_done       in   NODES                  1-cycle pulse: node n finished its task
// dispatch_valid  out  1                      dispatch offer valid
// dispatch_node   out  $clog2(NODES)          selected node id
// dispatch_task   out  TASK_W                 task for that node (queue head)
// dispatch_ready  in   1                      downstream accepts offer
// busy_mask       out  NODES                  1 = node holds a dispatched, unfinished task
// queue_count     out  $clog2(FIFO_DEPTH+1)   tasks queued (incl. one under offer)
// BEHAVIOUR
// - Reset (async assert, sync-release use): dispatch_valid=0, dispatch_node=0,
//   dispatch_task=0, busy_mask=0, queue_count=0, task_ready=1, rr_ptr=0, state IDLE.
// - Queue: FIFO; push on task_valid&&task_ready; pop only on dispatch handshake.
//   Push+pop same edge: count unchanged. task_ready=0 when full; no push-while-full.
// - Eligible(n) = core_avail[n] && !busy_mask[n].
// - FSM IDLE: if count>0 and any eligible -> latch node = first eligible scanning
//   rr_ptr, rr_ptr+1, ... wrapping NODES-1 -> 0; latch head task; go OFFER.
//   Else stay IDLE. Latency: task accepted at edge E0 into empty queue with free core
//   -> dispatch_valid=1 after E1.
// - FSM OFFER: dispatch_valid=1; node/task held stable until dispatch_ready (no
//   retraction, even if core_avail of chosen node drops). On handshake edge: pop,
//   busy_mask[node]<=1, rr_ptr <= (node==NODES-1)?0:node+1, go IDLE (min 1 idle cycle
//   between dispatches).
// - core_done[n] clears busy_mask[n]; ignored if bit already 0. Done and handshake
//   to different nodes same edge: both applied. Done takes effect for eligibility the
//   cycle after.
// - core_avail only gates selection; deasserting it never clears busy_mask.
// - Reset mid-OFFER: offer dropped, queue and busy state lost.
// TESTING
// 1 Reset, core_avail=9'h001, push task 0x11 -> dispatch_valid after 1 cycle, node=0,
//   task=0x11; ready=1 -> busy_mask=9'h001, queue_count=0.
// 2 core_avail=9'h1FF, push 0xA0..0xA3, ready=1 -> nodes 0,1,2,3 in order; push 4 more
//   after core_done -> nodes 4,5,6,7 (rr continues, not restart at 0).
// 3 Push 5 tasks with dispatch_ready=0 -> task_ready=0 at count 4; 5th held by source;
//   dispatch_node/task stable across 10 stall cycles.
// 4 busy_mask=9'h1FF, queue non-empty -> no offer; pulse core_done[5] -> offer node 5
//   two cycles later.
// 5 rr_ptr=8, node 8 busy, node 0 eligible -> wrap selects node 0, rr_ptr=1.
// 6 Assert rst_n=0 during OFFER -> dispatch_valid=0 immediately, all state cleared.

Source files
------------

// File: rtl/mesh_task_scheduler.sv
// Task scheduler for the 3x3 mesh: queues task requests and hands each one to a free,
// available core picked round-robin, offering (node, task) over a valid/ready handshake.
module mesh_task_scheduler #(
    parameter int NODES      = 9,
    parameter int TASK_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             task_valid_i,
    input  logic [TASK_W-1:0]                task_id_i,
    output logic                             task_ready_o,
    input  logic [NODES-1:0]                 core_avail_i,
    input  logic [NODES-1:0]                 core_done_i,
    output logic                             dispatch_valid_o,
    output logic [$clog2(NODES)-1:0]         dispatch_node_o,
    output logic [TASK_W-1:0]                dispatch_task_o,
    input  logic                             dispatch_ready_i,
    output logic [NODES-1:0]                 busy_mask_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  queue_count_o
);

    localparam int NODE_W = $clog2(NODES);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = NODE_W + 1;

    typedef enum logic {IDLE, OFFER} state_e;

    state_e              state_q, state_d;
    logic [TASK_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NODE_W-1:0]   node_q, node_d;
    logic [TASK_W-1:0]   task_q, task_d;
    logic [NODE_W-1:0]   rr_q, rr_d;
    logic [NODES-1:0]    busy_q, busy_d;
    logic [NODES-1:0]    eligible;
    logic                push, pop, found;
    logic [NODE_W-1:0]   pick;
    logic [IDX_W-1:0]    idx;

    assign task_ready_o     = (count_q < CNT_W'(FIFO_DEPTH));
    assign push             = task_valid_i && task_ready_o;
    assign pop              = (state_q == OFFER) && dispatch_ready_i;
    assign eligible         = core_avail_i & ~busy_q;
    assign dispatch_valid_o = (state_q == OFFER);
    assign dispatch_node_o  = node_q;
    assign dispatch_task_o  = task_q;
    assign busy_mask_o      = busy_q;
    assign queue_count_o    = count_q;

    // First eligible node at or after the round-robin pointer, wrapping past the last node.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NODES; i++) begin
            idx = {1'b0, rr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NODES)) begin
                idx = idx - IDX_W'(NODES);
            end
            if (!found && eligible[idx[NODE_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[NODE_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        task_d  = task_q;
        rr_d    = rr_q;
        busy_d  = busy_q & ~core_done_i;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && found) begin
                    node_d  = pick;
                    task_d  = mem_q[rd_ptr_q];
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (dispatch_ready_i) begin
                    busy_d[node_q] = 1'b1;
                    rr_d    = (node_q == NODE_W'(NODES - 1)) ? '0 : node_q + NODE_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            node_q  <= '0;
            task_q  <= '0;
            rr_q    <= '0;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            task_q  <= task_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= task_id_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mesh_task_scheduler.sv
// Scoreboard bench for mesh_task_scheduler: directed scenarios then random traffic,
// checked each cycle against a queue-and-array reference model of the scheduling rules.
module tb_mesh_task_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       task_valid = 1'b0;
    logic [7:0] task_id = '0;
    logic       task_ready;
    logic [8:0] core_avail = '0;
    logic [8:0] core_done = '0;
    logic       dispatch_valid;
    logic [3:0] dispatch_node;
    logic [7:0] dispatch_task;
    logic       dispatch_ready = 1'b0;
    logic [8:0] busy_mask;
    logic [2:0] queue_count;

    int checks = 0;
    int failures = 0;

    mesh_task_scheduler #(.NODES(9), .TASK_W(8), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .task_valid_i(task_valid), .task_id_i(task_id), .task_ready_o(task_ready),
        .core_avail_i(core_avail), .core_done_i(core_done),
        .dispatch_valid_o(dispatch_valid), .dispatch_node_o(dispatch_node),
        .dispatch_task_o(dispatch_task), .dispatch_ready_i(dispatch_ready),
        .busy_mask_o(busy_mask), .queue_count_o(queue_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int scanPick(input logic [8:0] elig, input int rr);
        for (int k = 0; k < 9; k++) begin
            if (elig[(rr + k) % 9]) return (rr + k) % 9;
        end
        return -1;
    endfunction

    // Reference model: pending tasks, per-node busy flags and the rotation pointer.
    logic [7:0] expQ[$];
    logic [8:0] mb = '0;
    int         rr = 0;
    int         offerNode = 0;
    logic [7:0] offerTask = '0;
    logic       prevValid = 1'b0;
    logic       prevHs = 1'b0;
    int         prevCnt = 0;
    logic [8:0] prevElig = '0;
    logic       expValid;

    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            mb        = '0;
            rr        = 0;
            prevValid = 1'b0;
            prevHs    = 1'b0;
            prevCnt   = 0;
            prevElig  = core_avail;
        end else begin
            expValid = prevValid ? !prevHs : (prevCnt > 0 && prevElig != '0);
            checkOutput("dispatch_valid", int'(dispatch_valid), int'(expValid));
            if (dispatch_valid && expValid) begin
                if (!prevValid) begin
                    offerNode = scanPick(prevElig, rr);
                    offerTask = (expQ.size() > 0) ? expQ[0] : 8'h00;
                end
                checkOutput("dispatch_node", int'(dispatch_node), offerNode);
                checkOutput("dispatch_task", int'(dispatch_task), int'(offerTask));
            end
            checkOutput("busy_mask", int'(busy_mask), int'(mb));
            checkOutput("queue_count", int'(queue_count), expQ.size());
            checkOutput("task_ready", int'(task_ready), int'(expQ.size() < 4));

            prevValid = dispatch_valid;
            prevHs    = dispatch_valid && dispatch_ready;
            prevCnt   = expQ.size();
            prevElig  = core_avail & ~mb;

            mb = mb & ~core_done;
            if (task_valid && expQ.size() < 4) expQ.push_back(task_id);
            if (prevHs) begin
                if (expQ.size() > 0) void'(expQ.pop_front());
                if (offerNode >= 0) begin
                    mb[offerNode] = 1'b1;
                    rr = (offerNode == 8) ? 0 : offerNode + 1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] id, input logic rdy,
                                 input logic [8:0] done, input logic [8:0] avail);
        task_valid     = v;
        task_id        = id;
        dispatch_ready = rdy;
        core_done      = done;
        core_avail     = avail;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic rdy, input logic [8:0] avail);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy, 9'h000, avail);
    endtask

    task automatic pushTask(input logic [7:0] id, input logic rdy, input logic [8:0] avail);
        logic accepted;
        for (int t = 0; t < 12; t++) begin
            accepted = task_ready;
            applyStimulus(1'b1, id, rdy, 9'h000, avail);
            if (accepted) break;
        end
        task_valid = 1'b0;
    endtask

    task automatic doReset(input logic [8:0] avail);
        rst_n = 1'b0;
        task_valid = 1'b0;
        dispatch_ready = 1'b0;
        core_done = '0;
        core_avail = avail;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", int'(dispatch_valid), 0);
        checkOutput("reset_node", int'(dispatch_node), 0);
        checkOutput("reset_task", int'(dispatch_task), 0);
        checkOutput("reset_ready", int'(task_ready), 1);
        rst_n = 1'b1;
    endtask

    initial begin
        // Single populated node takes the first task.
        doReset(9'h001);
        pushTask(8'h11, 1'b1, 9'h001);
        idleCycles(4, 1'b1, 9'h001);

        // Rotation continues after completions instead of restarting at node 0.
        doReset(9'h1FF);
        for (int i = 0; i < 4; i++) pushTask(8'hA0 + 8'(i), 1'b1, 9'h1FF);
        idleCycles(6, 1'b1, 9'h1FF);
        applyStimulus(1'b0, 8'h00, 1'b1, 9'h1FF, 9'h1FF);
        for (int i = 4; i < 8; i++) pushTask(8'hA0 + 8'(i), 1'b1, 9'h1FF);
        idleCycles(6, 1'b1, 9'h1FF);

        // Downstream stall fills the queue; the offer must stay put.
        doReset(9'h1FF);
        for (int i = 0; i < 5; i++) pushTask(8'hB0 + 8'(i), 1'b0, 9'h1FF);
        idleCycles(10, 1'b0, 9'h1FF);
        idleCycles(12, 1'b1, 9'h1FF);

        // All cores busy, then a single completion on node 5, then wrap from node 8 to 0.
        doReset(9'h1FF);
        for (int i = 0; i < 9; i++) pushTask(8'hC0 + 8'(i), 1'b1, 9'h1FF);
        idleCycles(3, 1'b1, 9'h1FF);
        pushTask(8'hC9, 1'b1, 9'h1FF);
        idleCycles(4, 1'b1, 9'h1FF);
        applyStimulus(1'b0, 8'h00, 1'b1, 9'h020, 9'h1FF);
        idleCycles(4, 1'b1, 9'h1FF);
        applyStimulus(1'b0, 8'h00, 1'b1, 9'h080, 9'h1FF);
        pushTask(8'hCA, 1'b1, 9'h1FF);
        idleCycles(4, 1'b1, 9'h1FF);
        applyStimulus(1'b0, 8'h00, 1'b1, 9'h001, 9'h1FF);
        pushTask(8'hCB, 1'b1, 9'h1FF);
        idleCycles(4, 1'b1, 9'h1FF);

        // Asynchronous reset in the middle of an offer.
        doReset(9'h1FF);
        pushTask(8'hD0, 1'b1, 9'h1FF);
        idleCycles(3, 1'b1, 9'h1FF);
        pushTask(8'hD1, 1'b0, 9'h1FF);
        idleCycles(3, 1'b0, 9'h1FF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", int'(dispatch_valid), 0);
        checkOutput("midreset_busy", int'(busy_mask), 0);
        checkOutput("midreset_count", int'(queue_count), 0);
        checkOutput("midreset_ready", int'(task_ready), 1);
        doReset(9'h1FF);

        // Random traffic with completions and changing availability.
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) core_avail = 9'($urandom) | 9'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h000,
                          core_avail);
        end
        idleCycles(3, 1'b1, 9'h1FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
